alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
Execute stage wrapping the 20-bit ALU function set (logic, shift/rotate, inc/dec, add/addc/sub, compare) behind a valid/ready handshake. Accepts one operation per cycle from the decode/operand-fetch stage and computes it in one registered cycle. Holds the carry flag for ADDC chaining. Results and flags go into a 2-entry output FIFO consumed by the writeback stage.

Parameters:
WIDTH, 20, datapath width; shift amount is always b[3:0].
DEPTH, 2, output FIFO entries; only 2 is supported.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation offered
in_ready  output  1  stage can accept; equals (fifo_count < DEPTH)
op  input  4  opcode (encoding below)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head
result  output  WIDTH  FIFO head result
zero  output  1  FIFO head zero flag
sign  output  1  FIFO head sign flag
c_out  output  1  FIFO head carry flag
carry_q  output  1  live carry flag register

Behaviour:
- Reset (rst=1 at an edge): fifo_count=0, out_valid=0, in_ready=1 after the edge, carry_q=0, result/zero/sign/c_out=0. Reset mid-operation drops all FIFO contents and any concurrent accept.
- Accept = in_valid & in_ready at a rising edge. The op is computed combinationally from a, b, op and carry_q, then pushed into the FIFO at the same edge.
- Latency: if the FIFO is empty, an op accepted at edge N gives out_valid=1 with its data after edge N.
- Pop = out_valid & out_ready. Simultaneous push and pop at count=2 is not possible because in_ready=0. At count=1, push and pop together keep the count at 1 with the new entry at the head. Order is strictly FIFO.
- While in_valid is low, inputs are ignored. With in_ready=0, inputs are held off and there is no state change.
- Opcodes (result r, all arithmetic mod 2^WIDTH):
  0 NOT r=~a
  1 AND r=a&b
  2 OR r=a|b
  3 XOR r=a^b
  4 SHFTL r=a<<b[3:0], zero fill
  5 SHFTR r=a>>b[3:0], logical
  6 ROTL r=rotate a left 1
  7 ROTR r=rotate a right 1
  8 INC r=a+1
  9 DEC r=a-1
  10 ADD r=a+b
  11 ADDC r=a+b+carry_q
  12 SUB r=a-b
  13 EQ r={0..,a==b}
  14 GT r={0..,a>b} unsigned
  15 LT r={0..,a<b} unsigned
- Flags pushed with each entry:
  - zero=(r==0), except EQ/GT/LT where zero=(a==b).
  - sign=r[WIDTH-1], except GT/LT where sign=(a<b).
  - c_out: INC/ADD/ADDC give carry out of bit WIDTH-1; DEC/SUB give borrow (1 when a<b, or a==0 for DEC); all other ops give c_out=carry_q, unchanged.
- carry_q updates on accept only, to the new c_out. Back-to-back ADD then ADDC chains correctly with no bubble.
- Wrap-around: INC of 0xFFFFF gives r=0, zero=1, c_out=1. DEC of 0 gives r=0xFFFFF, c_out=1.

Optional Feature:
ALU_EXEC_OVF_EN: adds output port ovf (1 bit), a FIFO-head signed-overflow flag stored per entry.
- ADD/ADDC/INC: ovf=1 when the operand signs match and the result sign differs.
- SUB/DEC: ovf=1 when the operand signs differ and the result sign differs from a.
- Other ops: ovf=0.
- Reset value: 0.
Without the macro, the port and its storage do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset, then ADD a=0x00005 b=0x00003 with out_ready=1 -> out_valid after 1 edge, result=0x00008, zero=0, sign=0, c_out=0.
- ADD a=0xFFFFF b=0x00001 then ADDC a=0 b=0 back-to-back -> result 0x00000 (zero=1, c_out=1), then result 0x00001 (c_out=0); carry_q ends 0.
- out_ready=0, three ops offered -> two accepted, in_ready=0 on third; raise out_ready -> results in order, third accepted after first pop.
- SUB a=3 b=5 -> result=0xFFFFE, sign=1, c_out=1; LT a=3 b=5 -> result=1, sign=1, zero=0.
- SHFTL a=0x80001 b=0x4 -> 0x00010; ROTR a=0x00001 -> 0x80000.
- Assert rst with 2 entries queued -> next cycle out_valid=0, in_ready=1, carry_q=0.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// Handshake and payload bundle between operand fetch, the ALU execute stage and writeback.
// ALU_EXEC_OVF_EN adds the per-entry signed-overflow flag ovf.
interface alu_exec_stage_if #(
    parameter int unsigned WIDTH = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             sign;
    logic             c_out;
`ifdef ALU_EXEC_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, sign, c_out
`ifdef ALU_EXEC_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, sign, c_out
`ifdef ALU_EXEC_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Single-cycle ALU execute stage with carry register and 2-entry output FIFO.
// Optional ALU_EXEC_OVF_EN adds a stored signed-overflow flag (bus.ovf).
module alu_exec_stage #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    alu_exec_stage_if.slave  bus,
    output logic             carry_q
);
    localparam int unsigned MSB   = WIDTH - 1;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [3:0] {
        OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SHFTL, OP_SHFTR, OP_ROTL, OP_ROTR,
        OP_INC, OP_DEC, OP_ADD, OP_ADDC, OP_SUB, OP_EQ, OP_GT, OP_LT
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             sign;
        logic             c_out;
`ifdef ALU_EXEC_OVF_EN
        logic             ovf;
`endif
    } entry_t;

    op_e              op;
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   sum;
    logic             c_new;
    entry_t           new_entry;
    entry_t           head_q;
    entry_t           tail_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    assign op = op_e'(bus.op);

    // ALU result and carry/borrow for the offered operation
    always_comb begin
        r     = '0;
        sum   = '0;
        c_new = carry_q;
        case (op)
            OP_NOT:   r = ~bus.a;
            OP_AND:   r = bus.a & bus.b;
            OP_OR:    r = bus.a | bus.b;
            OP_XOR:   r = bus.a ^ bus.b;
            OP_SHFTL: r = bus.a << bus.b[3:0];
            OP_SHFTR: r = bus.a >> bus.b[3:0];
            OP_ROTL:  r = {bus.a[MSB-1:0], bus.a[MSB]};
            OP_ROTR:  r = {bus.a[0], bus.a[MSB:1]};
            OP_INC: begin
                sum   = {1'b0, bus.a} + (WIDTH+1)'(1);
                r     = sum[MSB:0];
                c_new = sum[WIDTH];
            end
            OP_DEC: begin
                r     = bus.a - WIDTH'(1);
                c_new = (bus.a == '0);
            end
            OP_ADD: begin
                sum   = {1'b0, bus.a} + {1'b0, bus.b};
                r     = sum[MSB:0];
                c_new = sum[WIDTH];
            end
            OP_ADDC: begin
                sum   = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(carry_q);
                r     = sum[MSB:0];
                c_new = sum[WIDTH];
            end
            OP_SUB: begin
                r     = bus.a - bus.b;
                c_new = (bus.a < bus.b);
            end
            OP_EQ:    r = WIDTH'(bus.a == bus.b);
            OP_GT:    r = WIDTH'(bus.a > bus.b);
            OP_LT:    r = WIDTH'(bus.a < bus.b);
        endcase
    end

    // Flags; compares report equality/ordering instead of result properties
    always_comb begin
        new_entry        = '0;
        new_entry.result = r;
        new_entry.zero   = (r == '0);
        new_entry.sign   = r[MSB];
        new_entry.c_out  = c_new;
        if (op == OP_EQ || op == OP_GT || op == OP_LT) begin
            new_entry.zero = (bus.a == bus.b);
        end
        if (op == OP_GT || op == OP_LT) begin
            new_entry.sign = (bus.a < bus.b);
        end
`ifdef ALU_EXEC_OVF_EN
        case (op)
            OP_INC:          new_entry.ovf = ~bus.a[MSB] & r[MSB];
            OP_DEC:          new_entry.ovf = bus.a[MSB] & ~r[MSB];
            OP_ADD, OP_ADDC: new_entry.ovf = (bus.a[MSB] == bus.b[MSB]) && (r[MSB] != bus.a[MSB]);
            OP_SUB:          new_entry.ovf = (bus.a[MSB] != bus.b[MSB]) && (r[MSB] != bus.a[MSB]);
            default:         new_entry.ovf = 1'b0;
        endcase
`endif
    end

    assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Shift-style FIFO: head_q always holds the oldest entry
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            if (push) begin
                carry_q <= c_new;
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == '0) head_q <= new_entry;
                    else               tail_q <= new_entry;
                    count_q <= count_q + CNT_W'(1);
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - CNT_W'(1);
                end
                2'b11:   head_q <= new_entry;
                default: ;
            endcase
        end
    end

    assign bus.result = head_q.result;
    assign bus.zero   = head_q.zero;
    assign bus.sign   = head_q.sign;
    assign bus.c_out  = head_q.c_out;
`ifdef ALU_EXEC_OVF_EN
    assign bus.ovf    = head_q.ovf;
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: arithmetic reference model, directed and random ops.
module tb_alu_exec_stage;
    localparam int unsigned WIDTH = 20;
    localparam longint M    = 64'd1 << WIDTH;
    localparam longint HALF = M / 2;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             sign;
        logic             c_out;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic carry_q;
    always #5 clk = ~clk;

    alu_exec_stage_if #(.WIDTH(WIDTH)) bus();

    alu_exec_stage #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .carry_q (carry_q)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];
    bit   mcarry = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit out_rng(input longint x);
        return (x < -HALF) || (x > HALF - 1);
    endfunction

    // Reference model from the opcode definitions, using plain integer arithmetic
    function automatic exp_t model(input logic [3:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        longint ua = longint'(x);
        longint ub = longint'(y);
        longint sa = (ua >= HALF) ? ua - M : ua;
        longint sb = (ub >= HALF) ? ub - M : ub;
        longint t;
        longint res = 0;
        bit c = mcarry;
        bit v = 1'b0;
        exp_t e;
        case (o)
            4'd0:  res = M - 1 - ua;
            4'd1:  res = ua & ub;
            4'd2:  res = ua | ub;
            4'd3:  res = ua ^ ub;
            4'd4:  res = (ua << (ub % 16)) % M;
            4'd5:  res = ua >> (ub % 16);
            4'd6:  res = (ua * 2) % M + ua / HALF;
            4'd7:  res = ua / 2 + (ua % 2) * HALF;
            4'd8:  begin t = ua + 1; res = t % M; c = (t >= M); v = out_rng(sa + 1); end
            4'd9:  begin res = (ua + M - 1) % M; c = (ua == 0); v = out_rng(sa - 1); end
            4'd10: begin t = ua + ub; res = t % M; c = (t >= M); v = out_rng(sa + sb); end
            4'd11: begin
                t = ua + ub + longint'(mcarry); res = t % M; c = (t >= M);
                v = out_rng(sa + sb + longint'(mcarry));
            end
            4'd12: begin res = (ua + M - ub) % M; c = (ua < ub); v = out_rng(sa - sb); end
            4'd13: res = (ua == ub) ? 1 : 0;
            4'd14: res = (ua > ub) ? 1 : 0;
            default: res = (ua < ub) ? 1 : 0;
        endcase
        e.result = WIDTH'(res);
        e.zero   = (o >= 4'd13) ? (ua == ub) : (res == 0);
        e.sign   = (o == 4'd14 || o == 4'd15) ? (ua < ub) : (res >= HALF);
        e.c_out  = c;
`ifdef ALU_EXEC_OVF_EN
        e.ovf    = v;
`else
        e.ovf    = 1'b0;
`endif
        mcarry = c;
        return e;
    endfunction

    // Offer one op, wait (bounded) for acceptance, push the expected entry
    task automatic issue(input logic [3:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a  = x;
        bus.b  = y;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sbq.push_back(model(o, x, y));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
        else       check("carry_q", 64'(carry_q), 64'(mcarry));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom % 5)
            0: return '0;
            1: return '1;
            2: return WIDTH'(32'h80000 ^ ($urandom % 4));
            3: return WIDTH'($urandom % 8);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Monitor: compare every popped head against the scoreboard
    initial begin
        exp_t g;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                g.result = bus.result;
                g.zero   = bus.zero;
                g.sign   = bus.sign;
                g.c_out  = bus.c_out;
`ifdef ALU_EXEC_OVF_EN
                g.ovf    = bus.ovf;
`else
                g.ovf    = 1'b0;
`endif
                if (sbq.size() == 0) begin
                    check("unexpected_output", 64'(g), 64'hDEAD_BEEF_0000);
                end else begin
                    e = sbq.pop_front();
                    check("entry{result,zero,sign,c_out,ovf}", 64'(g), 64'(e));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom % 3) != 0;
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_carry_q", 64'(carry_q), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);

        issue(4'd10, 20'h00005, 20'h00003);
        check("latency_out_valid", 64'(bus.out_valid), 64'd1);
        idle(2);

        issue(4'd10, 20'hFFFFF, 20'h00001);
        issue(4'd11, 20'h00000, 20'h00000);
        idle(2);
        check("addc_chain_carry_end", 64'(carry_q), 64'd0);

        // FIFO fills at two entries; third op waits for the first pop
        bus.out_ready = 1'b0;
        fork
            begin
                issue(4'd3, 20'h12345, 20'h0F0F0);
                issue(4'd1, 20'hABCDE, 20'h0FFFF);
                issue(4'd2, 20'h10000, 20'h00001);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                check("full_in_ready", 64'(bus.in_ready), 64'd0);
                check("full_out_valid", 64'(bus.out_valid), 64'd1);
                bus.out_ready = 1'b1;
                @(posedge clk);
                #2;
                check("after_pop_in_ready", 64'(bus.in_ready), 64'd1);
            end
        join
        idle(3);

        issue(4'd12, 20'd3, 20'd5);
        issue(4'd15, 20'd3, 20'd5);
        issue(4'd14, 20'd9, 20'd5);
        issue(4'd13, 20'd7, 20'd7);
        issue(4'd4, 20'h80001, 20'h4);
        issue(4'd7, 20'h00001, 20'h0);
        issue(4'd6, 20'h80000, 20'h0);
        issue(4'd5, 20'h80000, 20'h13);
        issue(4'd8, 20'hFFFFF, 20'h0);
        issue(4'd9, 20'h00000, 20'h0);
        issue(4'd0, 20'h0F0F0, 20'h0);
        issue(4'd8, 20'h7FFFF, 20'h0);
        issue(4'd12, 20'h80000, 20'h00001);
        idle(3);

        // Reset with two entries queued and carry set
        bus.out_ready = 1'b0;
        issue(4'd10, 20'hFFFFF, 20'h00001);
        issue(4'd0, 20'h00000, 20'h00000);
        idle(1);
        check("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        mcarry = 1'b0;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_carry_q", 64'(carry_q), 64'd0);
        check("mid_rst_result", 64'({bus.result, bus.zero, bus.sign, bus.c_out}), 64'd0);
        bus.out_ready = 1'b1;

        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            issue(4'($urandom % 16), pick(), pick());
            if ($urandom % 6 == 0) idle(1);
        end
        idle(1);
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", 64'(sbq.size()), 64'd0);
        check("drain_out_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
